// File: rtl/commit_trace_buffer_if.sv
// Commit-port and trace-stream bundle for commit_trace_buffer.
// master: ROB/checker side; slave: the trace buffer.
interface commit_trace_buffer_if #(
    parameter int unsigned width = 32,
    parameter int unsigned size  = 8,
    parameter int unsigned depth = 16
);
    localparam int unsigned idx_w = $clog2(size);
    localparam int unsigned cnt_w = $clog2(depth) + 1;

    // ROB commit port
    logic               commit;
    logic [idx_w-1:0]   commit_head;
    logic [size-1:0]    commit_rdy;
    logic [width-1:0]   commit_pc     [size];
    logic [6:0]         commit_opcode [size];
    logic [4:0]         commit_rd     [size];
    logic [width-1:0]   commit_data   [size];
    logic               rob_hold;

    // Serialized trace stream
    logic               out_valid;
    logic               out_ready;
    logic [width-1:0]   out_pc;
    logic [6:0]         out_opcode;
    logic [4:0]         out_rd;
    logic [width-1:0]   out_data;
    logic [31:0]        out_seq;

    // Status
    logic [cnt_w-1:0]   count;
    logic               overflow;

    modport master (
        output commit, commit_head, commit_rdy, commit_pc, commit_opcode,
               commit_rd, commit_data, out_ready,
        input  rob_hold, out_valid, out_pc, out_opcode, out_rd, out_data,
               out_seq, count, overflow
    );

    modport slave (
        input  commit, commit_head, commit_rdy, commit_pc, commit_opcode,
               commit_rd, commit_data, out_ready,
        output rob_hold, out_valid, out_pc, out_opcode, out_rd, out_data,
               out_seq, count, overflow
    );
endinterface

// File: rtl/commit_trace_buffer.sv
// Serializes multi-entry ROB retirements into an in-order, one-per-cycle
// trace stream. All-or-nothing enqueue; dropped commits set a sticky flag.
module commit_trace_buffer #(
    parameter int unsigned width = 32,
    parameter int unsigned size  = 8,
    parameter int unsigned depth = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    commit_trace_buffer_if.slave  bus
);
    localparam int unsigned idx_w = $clog2(size);
    localparam int unsigned ptr_w = $clog2(depth);
    localparam int unsigned cnt_w = ptr_w + 1;
    localparam int unsigned k_w   = $clog2(size) + 1;

    typedef struct packed {
        logic [width-1:0] pc;
        logic [6:0]       opcode;
        logic [4:0]       rd;
        logic [width-1:0] data;
    } entry_t;

    entry_t            mem [depth];
    logic [ptr_w-1:0]  head;
    logic [ptr_w-1:0]  tail;
    logic [cnt_w-1:0]  count;
    logic [31:0]       seq;
    logic              overflow;

    logic              wr_en    [size];
    logic [ptr_w-1:0]  wr_slot  [size];
    entry_t            wr_entry [size];
    logic [k_w-1:0]    k;
    logic [idx_w-1:0]  scan_idx;
    logic [cnt_w-1:0]  free_slots;
    logic              fits;
    logic              enq;
    logic              drop;
    logic              deq;

    // Scan the ROB from commit_head and pack retiring entries in program order
    always_comb begin
        k        = '0;
        scan_idx = '0;
        for (int i = 0; i < int'(size); i++) begin
            scan_idx           = bus.commit_head + idx_w'(i);
            wr_en[i]           = bus.commit_rdy[scan_idx];
            wr_slot[i]         = tail + ptr_w'(k);
            wr_entry[i].pc     = bus.commit_pc[scan_idx];
            wr_entry[i].opcode = bus.commit_opcode[scan_idx];
            wr_entry[i].rd     = bus.commit_rd[scan_idx];
            wr_entry[i].data   = (bus.commit_rd[scan_idx] == 5'd0) ? '0 : bus.commit_data[scan_idx];
            k                  = k + k_w'(bus.commit_rdy[scan_idx]);
        end
    end

    // Capacity is judged on start-of-cycle occupancy; a same-cycle pop does not help
    always_comb begin
        free_slots = cnt_w'(depth) - count;
        fits       = (cnt_w'(k) <= free_slots);
        enq        = bus.commit && !rst && (k != '0) && fits;
        drop       = bus.commit && !rst && !fits;
        deq        = (count != '0) && bus.out_ready;
    end

    // Pointer, occupancy, sequence and sticky overflow state
    always_ff @(posedge clk) begin
        if (rst) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            seq      <= '0;
            overflow <= 1'b0;
        end else begin
            if (enq) begin
                tail <= tail + ptr_w'(k);
            end
            if (deq) begin
                head <= head + ptr_w'(1);
                seq  <= seq + 32'd1;
            end
            count <= count + cnt_w'(enq ? k : k_w'(0)) - cnt_w'(deq);
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    // Trace storage; contents are don't-care after reset
    always_ff @(posedge clk) begin
        if (enq) begin
            for (int i = 0; i < int'(size); i++) begin
                if (wr_en[i]) begin
                    mem[wr_slot[i]] <= wr_entry[i];
                end
            end
        end
    end

    // Head of trace presented straight from storage
    assign bus.out_valid  = (count != '0);
    assign bus.out_pc     = mem[head].pc;
    assign bus.out_opcode = mem[head].opcode;
    assign bus.out_rd     = mem[head].rd;
    assign bus.out_data   = mem[head].data;
    assign bus.out_seq    = seq;
    assign bus.count      = count;
    assign bus.overflow   = overflow;
    assign bus.rob_hold   = (free_slots < cnt_w'(size));

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Self-checking bench for commit_trace_buffer: vector table plus queue model.
module tb_commit_trace_buffer;
    localparam int unsigned W = 32;
    localparam int unsigned S = 8;
    localparam int unsigned D = 16;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    commit_trace_buffer_if #(.width(W), .size(S), .depth(D)) bus ();

    commit_trace_buffer #(.width(W), .size(S), .depth(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] pc;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        logic        commit;
        logic [2:0]  head;
        logic [7:0]  rdy;
        logic [31:0] base;
        logic [4:0]  rd_off;
        logic        ready;
        int          e_count;
        logic        e_hold;
        logic        e_ovf;
    } vec_t;

    exp_t        sb[$];
    vec_t        vecs[$];
    int          n_cmp;
    int          n_bad;
    logic [31:0] m_seq;
    logic        m_ovf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one ROB commit vector; pcs ascend by 4 in scan order from head
    task automatic drive(input logic c, input logic [2:0] h, input logic [7:0] r,
                         input logic [31:0] base, input logic [4:0] rd_off, input logic rdy_o);
        logic [2:0] off;
        bus.commit      = c;
        bus.commit_head = h;
        bus.commit_rdy  = r;
        bus.out_ready   = rdy_o;
        for (int i = 0; i < 8; i++) begin
            off                  = 3'(i) - h;
            bus.commit_pc[i]     = base + 32'(off) * 32'd4;
            bus.commit_opcode[i] = 7'h13 + 7'(i);
            bus.commit_rd[i]     = 5'(i) + rd_off;
            bus.commit_data[i]   = (32'(i) << 8) | 32'd5;
        end
    endtask

    // Check outputs mid-cycle, then advance the queue model across the next edge
    task automatic step(input logic tbl, input int e_count, input logic e_hold, input logic e_ovf);
        exp_t       tmp[$];
        exp_t       e;
        int         k;
        logic       deq;
        logic [2:0] idx;
        @(negedge clk);
        chk("count",     32'(bus.count),     32'(sb.size()));
        chk("out_valid", 32'(bus.out_valid), 32'(sb.size() != 0));
        chk("rob_hold",  32'(bus.rob_hold),  32'((D - 32'(sb.size())) < S));
        chk("overflow",  32'(bus.overflow),  32'(m_ovf));
        chk("out_seq",   bus.out_seq,        m_seq);
        if (sb.size() != 0) begin
            chk("out_pc",     bus.out_pc,             sb[0].pc);
            chk("out_opcode", 32'(bus.out_opcode),    32'(sb[0].opcode));
            chk("out_rd",     32'(bus.out_rd),        32'(sb[0].rd));
            chk("out_data",   bus.out_data,           sb[0].data);
        end
        if (tbl) begin
            chk("vec_count",    32'(bus.count),    32'(e_count));
            chk("vec_rob_hold", 32'(bus.rob_hold), 32'(e_hold));
            chk("vec_overflow", 32'(bus.overflow), 32'(e_ovf));
        end
        if (rst) begin
            sb.delete();
            m_seq = 32'd0;
            m_ovf = 1'b0;
        end else begin
            deq = (sb.size() != 0) && bus.out_ready;
            k   = $countones(bus.commit_rdy);
            if (bus.commit) begin
                if (k > int'(D) - sb.size()) begin
                    m_ovf = 1'b1;
                end else begin
                    for (int i = 0; i < 8; i++) begin
                        idx = bus.commit_head + 3'(i);
                        if (bus.commit_rdy[idx]) begin
                            e.pc     = bus.commit_pc[idx];
                            e.opcode = bus.commit_opcode[idx];
                            e.rd     = bus.commit_rd[idx];
                            e.data   = (bus.commit_rd[idx] == 5'd0) ? 32'd0 : bus.commit_data[idx];
                            tmp.push_back(e);
                        end
                    end
                end
            end
            if (deq) begin
                void'(sb.pop_front());
                m_seq = m_seq + 32'd1;
            end
            foreach (tmp[j]) sb.push_back(tmp[j]);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        m_seq = 32'd0;
        m_ovf = 1'b0;

        // commit head rdy base rd_off ready | count hold ovf observed this cycle
        vecs.push_back('{1'b1, 3'd0, 8'h07, 32'h060, 5'd1, 1'b1, 0, 1'b0, 1'b0}); // 3 in-order entries
        vecs.push_back('{1'b0, 3'd0, 8'h00, 32'h000, 5'd1, 1'b1, 3, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 3'd0, 8'h00, 32'h000, 5'd1, 1'b1, 2, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 3'd0, 8'h00, 32'h000, 5'd1, 1'b1, 1, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 3'd6, 8'hC3, 32'h100, 5'd1, 1'b1, 0, 1'b0, 1'b0}); // wrap 6,7,0,1
        vecs.push_back('{1'b0, 3'd0, 8'h00, 32'h000, 5'd1, 1'b0, 4, 1'b0, 1'b0}); // stall
        vecs.push_back('{1'b0, 3'd0, 8'h00, 32'h000, 5'd1, 1'b1, 4, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 3'd0, 8'h00, 32'h000, 5'd1, 1'b1, 3, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 3'd0, 8'h00, 32'h000, 5'd1, 1'b1, 2, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 3'd0, 8'h00, 32'h000, 5'd1, 1'b1, 1, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 3'd0, 8'h01, 32'h080, 5'd0, 1'b1, 0, 1'b0, 1'b0}); // rd=0 entry
        vecs.push_back('{1'b0, 3'd0, 8'h00, 32'h000, 5'd1, 1'b1, 1, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 3'd0, 8'hFF, 32'h200, 5'd1, 1'b0, 0, 1'b0, 1'b0}); // full vector
        vecs.push_back('{1'b1, 3'd3, 8'h08, 32'h300, 5'd1, 1'b0, 8, 1'b0, 1'b0}); // to 9
        vecs.push_back('{1'b1, 3'd0, 8'hFF, 32'h400, 5'd1, 1'b0, 9, 1'b1, 1'b0}); // dropped
        vecs.push_back('{1'b0, 3'd0, 8'h00, 32'h000, 5'd1, 1'b1, 9, 1'b1, 1'b1});
        vecs.push_back('{1'b0, 3'd0, 8'h00, 32'h000, 5'd1, 1'b1, 8, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 3'd0, 8'h00, 32'h000, 5'd1, 1'b1, 7, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 3'd0, 8'h00, 32'h000, 5'd1, 1'b1, 6, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 3'd0, 8'h00, 32'h000, 5'd1, 1'b1, 5, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 3'd0, 8'h00, 32'h000, 5'd1, 1'b1, 4, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 3'd0, 8'h00, 32'h000, 5'd1, 1'b1, 3, 1'b0, 1'b1});
        vecs.push_back('{1'b1, 3'd2, 8'h1C, 32'h500, 5'd1, 1'b1, 2, 1'b0, 1'b1}); // enq+deq
        vecs.push_back('{1'b0, 3'd0, 8'h00, 32'h000, 5'd1, 1'b1, 4, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 3'd0, 8'h00, 32'h000, 5'd1, 1'b1, 3, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 3'd0, 8'h00, 32'h000, 5'd1, 1'b1, 2, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 3'd0, 8'h00, 32'h000, 5'd1, 1'b1, 1, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 3'd0, 8'h00, 32'h000, 5'd1, 1'b0, 0, 1'b0, 1'b1});

        rst = 1'b1;
        drive(1'b0, 3'd0, 8'h00, 32'h0, 5'd1, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].commit, vecs[i].head, vecs[i].rdy, vecs[i].base,
                  vecs[i].rd_off, vecs[i].ready);
            step(1'b1, vecs[i].e_count, vecs[i].e_hold, vecs[i].e_ovf);
        end

        // Reset mid-burst: load 5, then reset while committing 8 more
        drive(1'b1, 3'd0, 8'h1F, 32'h600, 5'd1, 1'b0);
        step(1'b1, 0, 1'b0, 1'b1);
        drive(1'b1, 3'd0, 8'hFF, 32'h700, 5'd1, 1'b0);
        rst = 1'b1;
        step(1'b1, 5, 1'b0, 1'b1);
        rst = 1'b0;
        drive(1'b0, 3'd0, 8'h00, 32'h0, 5'd1, 1'b1);
        step(1'b1, 0, 1'b0, 1'b0);
        step(1'b1, 0, 1'b0, 1'b0);

        // Back-to-back multi-entry commits draining under random back-pressure
        for (int n = 0; n < 20; n++) begin
            drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom),
                  32'h1000 + 32'(n) * 32'h40, 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 3) != 0));
            step(1'b0, 0, 1'b0, 1'b0);
        end
        drive(1'b0, 3'd0, 8'h00, 32'h0, 5'd1, 1'b1);
        for (int n = 0; n < 20; n++) begin
            step(1'b0, 0, 1'b0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
